hazard_ctrl: RTL and testbench

Pipeline-wide hazard controller for the five-stage MIPS core (F/D/E/M/W). It decodes the D-stage instruction into register-use times (Tuse) and write-back times (Tnew), tracks destination/Tnew of the instructions in E, M and W in internal shift registers, and produces stall, bubble and forwarding selects. It also owns the multiply/divide busy counter, with multiply and divide latencies set by parameters. The datapath sends it the D-stage instruction each cycle; the per-stage decoder drives the remaining control for E/M/W.

---
 rtl/hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the five-stage F/D/E/M/W core.
//
// Decodes the D-stage instruction into register-use times (Tuse) and result
// times (Tnew), shadows the destination/Tnew of the instructions in E, M and W,
// and produces the stall/bubble request plus the operand forwarding selects.
// It also owns the multiply/divide busy counter.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low; clears all state immediately
//   d_instr   in   32-bit instruction currently in D
//   stall     out  freeze PC and F/D register (combinational)
//   flush_e   out  load a bubble into D/E; always equal to stall
//   fwd_d_rs  out  D operand select: 00 regfile, 01 from M, 10 from E
//   fwd_d_rt  out  same for rt
//   fwd_e_rs  out  E operand select: 00 pipeline reg, 01 from M, 10 from W
//   fwd_e_rt  out  same for rt
//   md_busy   out  multiply/divide unit busy (counter non-zero)
//   w_a3      out  destination register of the W-stage instruction (0 = none)
//
// Handshake: there is no valid/ready pair here. D advances on every edge where
// stall is low; on every edge where stall is high D holds and exactly one
// bubble enters E.
//
// Source registers an instruction does not read are decoded as $0, so a bubble
// or a non-reading instruction can never match a stall or forwarding compare.

module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_instr,
    output logic        stall,
    output logic        flush_e,
    output logic [1:0]  fwd_d_rs,
    output logic [1:0]  fwd_d_rt,
    output logic [1:0]  fwd_e_rs,
    output logic [1:0]  fwd_e_rt,
    output logic        md_busy,
    output logic [4:0]  w_a3
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    // Instruction fields
    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [4:0] w_rs_f;
    logic [4:0] w_rt_f;
    logic [4:0] w_rd_f;
    logic [4:0] w_sh_f;

    assign w_op   = d_instr[31:26];
    assign w_fn   = d_instr[5:0];
    assign w_rs_f = d_instr[25:21];
    assign w_rt_f = d_instr[20:16];
    assign w_rd_f = d_instr[15:11];
    assign w_sh_f = d_instr[10:6];

    // Decoded D-stage fields
    logic [4:0] w_d_a3;
    logic [1:0] w_d_tnew;
    logic [4:0] w_d_rs;      // $0 when rs is not read
    logic [4:0] w_d_rt;      // $0 when rt is not read
    logic [1:0] w_tuse_rs;
    logic [1:0] w_tuse_rt;
    logic       w_d_md;      // mult/multu/div/divu
    logic       w_d_div;     // div/divu
    logic       w_d_hilo;    // any instruction touching the md unit or HI/LO

    // E/M/W shadow state
    logic [4:0]       r_e_a3;
    logic [1:0]       r_e_tnew;
    logic [4:0]       r_e_rs;
    logic [4:0]       r_e_rt;
    logic             r_e_md;
    logic             r_e_div;
    logic [4:0]       r_m_a3;
    logic [1:0]       r_m_tnew;
    logic [4:0]       r_w_a3;
    logic [CNT_W-1:0] r_cnt;

    always_comb begin
        w_d_a3    = 5'd0;
        w_d_tnew  = 2'd0;
        w_d_rs    = 5'd0;
        w_d_rt    = 5'd0;
        w_tuse_rs = 2'd0;
        w_tuse_rt = 2'd0;
        w_d_md    = 1'b0;
        w_d_div   = 1'b0;
        w_d_hilo  = 1'b0;
        // R-type with a non-zero shamt is not a supported encoding: nop.
        if (w_op == OP_RTYPE && w_sh_f == 5'd0) begin
            case (w_fn)
                FN_ADD, FN_SUB: begin
                    w_d_a3    = w_rd_f;
                    w_d_tnew  = 2'd1;
                    w_d_rs    = w_rs_f;
                    w_tuse_rs = 2'd1;
                    w_d_rt    = w_rt_f;
                    w_tuse_rt = 2'd1;
                end
                FN_MFHI, FN_MFLO: begin
                    w_d_a3   = w_rd_f;
                    w_d_tnew = 2'd1;
                    w_d_hilo = 1'b1;
                end
                FN_MTHI, FN_MTLO: begin
                    w_d_rs    = w_rs_f;
                    w_tuse_rs = 2'd1;
                    w_d_hilo  = 1'b1;
                end
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                    w_d_rs    = w_rs_f;
                    w_tuse_rs = 2'd1;
                    w_d_rt    = w_rt_f;
                    w_tuse_rt = 2'd1;
                    w_d_md    = 1'b1;
                    w_d_div   = (w_fn == FN_DIV) || (w_fn == FN_DIVU);
                    w_d_hilo  = 1'b1;
                end
                FN_JR: begin
                    w_d_rs    = w_rs_f;
                    w_tuse_rs = 2'd0;
                end
                default: ;
            endcase
        end else begin
            case (w_op)
                OP_ORI: begin
                    w_d_a3    = w_rt_f;
                    w_d_tnew  = 2'd1;
                    w_d_rs    = w_rs_f;
                    w_tuse_rs = 2'd1;
                end
                OP_LUI: begin
                    w_d_a3   = w_rt_f;
                    w_d_tnew = 2'd1;
                end
                OP_LW: begin
                    w_d_a3    = w_rt_f;
                    w_d_tnew  = 2'd2;
                    w_d_rs    = w_rs_f;
                    w_tuse_rs = 2'd1;
                end
                OP_SW: begin
                    w_d_rs    = w_rs_f;
                    w_tuse_rs = 2'd1;
                    w_d_rt    = w_rt_f;
                    w_tuse_rt = 2'd2;
                end
                OP_BEQ: begin
                    w_d_rs    = w_rs_f;
                    w_tuse_rs = 2'd0;
                    w_d_rt    = w_rt_f;
                    w_tuse_rt = 2'd0;
                end
                OP_JAL: begin
                    w_d_a3   = 5'd31;
                    w_d_tnew = 2'd0;
                end
                default: ;
            endcase
        end
    end

    // A source stalls when a producer in E or M will not have its result
    // before the consumer needs it (Tnew > Tuse).
    logic w_stall_rs;
    logic w_stall_rt;
    logic w_stall_md;

    assign w_stall_rs = (w_d_rs != 5'd0) &&
                        ((r_e_a3 == w_d_rs && r_e_tnew > w_tuse_rs) ||
                         (r_m_a3 == w_d_rs && r_m_tnew > w_tuse_rs));
    assign w_stall_rt = (w_d_rt != 5'd0) &&
                        ((r_e_a3 == w_d_rt && r_e_tnew > w_tuse_rt) ||
                         (r_m_a3 == w_d_rt && r_m_tnew > w_tuse_rt));
    // An md instruction in E has not loaded the counter yet, so it counts as busy.
    assign w_stall_md = w_d_hilo && (md_busy || r_e_md);

    assign stall   = w_stall_rs || w_stall_rt || w_stall_md;
    assign flush_e = stall;
    assign md_busy = (r_cnt != '0);
    assign w_a3    = r_w_a3;

    // D forwarding: E has priority over M; W is covered by the regfile bypass.
    assign fwd_d_rs = (w_d_rs != 5'd0 && r_e_a3 == w_d_rs && r_e_tnew == 2'd0) ? 2'b10 :
                      (w_d_rs != 5'd0 && r_m_a3 == w_d_rs && r_m_tnew == 2'd0) ? 2'b01 : 2'b00;
    assign fwd_d_rt = (w_d_rt != 5'd0 && r_e_a3 == w_d_rt && r_e_tnew == 2'd0) ? 2'b10 :
                      (w_d_rt != 5'd0 && r_m_a3 == w_d_rt && r_m_tnew == 2'd0) ? 2'b01 : 2'b00;

    // E forwarding: M has priority over W.
    assign fwd_e_rs = (r_e_rs != 5'd0 && r_m_a3 == r_e_rs && r_m_tnew == 2'd0) ? 2'b01 :
                      (r_e_rs != 5'd0 && r_w_a3 == r_e_rs) ? 2'b10 : 2'b00;
    assign fwd_e_rt = (r_e_rt != 5'd0 && r_m_a3 == r_e_rt && r_m_tnew == 2'd0) ? 2'b01 :
                      (r_e_rt != 5'd0 && r_w_a3 == r_e_rt) ? 2'b10 : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e_a3   <= 5'd0;
            r_e_tnew <= 2'd0;
            r_e_rs   <= 5'd0;
            r_e_rt   <= 5'd0;
            r_e_md   <= 1'b0;
            r_e_div  <= 1'b0;
            r_m_a3   <= 5'd0;
            r_m_tnew <= 2'd0;
            r_w_a3   <= 5'd0;
            r_cnt    <= '0;
        end else begin
            if (stall) begin
                r_e_a3   <= 5'd0;
                r_e_tnew <= 2'd0;
                r_e_rs   <= 5'd0;
                r_e_rt   <= 5'd0;
                r_e_md   <= 1'b0;
                r_e_div  <= 1'b0;
            end else begin
                r_e_a3   <= w_d_a3;
                r_e_tnew <= w_d_tnew;
                r_e_rs   <= w_d_rs;
                r_e_rt   <= w_d_rt;
                r_e_md   <= w_d_md;
                r_e_div  <= w_d_div;
            end
            r_m_a3   <= r_e_a3;
            r_m_tnew <= (r_e_tnew != 2'd0) ? (r_e_tnew - 2'd1) : 2'd0;
            r_w_a3   <= r_m_a3;
            if (r_e_md)
                r_cnt <= r_e_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            else if (r_cnt != '0)
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int OUT_W       = 16;
  localparam int B_STALL     = 15;
  localparam int B_BUSY      = 5;

  logic        clk;
  logic        reset;
  logic [31:0] d_instr;
  logic        stall;
  logic        flush_e;
  logic [1:0]  fwd_d_rs;
  logic [1:0]  fwd_d_rt;
  logic [1:0]  fwd_e_rs;
  logic [1:0]  fwd_e_rt;
  logic        md_busy;
  logic [4:0]  w_a3;

  int n_checks;
  int n_errors;

  logic [OUT_W-1:0] exp_q[$];

  hazard_ctrl #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .d_instr (d_instr),
    .stall   (stall),
    .flush_e (flush_e),
    .fwd_d_rs(fwd_d_rs),
    .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs),
    .fwd_e_rt(fwd_e_rt),
    .md_busy (md_busy),
    .w_a3    (w_a3)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_jal();
    return {6'h03, 26'h0000040};
  endfunction

  function automatic logic [OUT_W-1:0] mk_out(logic s, logic [1:0] fdrs, logic [1:0] fdrt,
                                               logic [1:0] fers, logic [1:0] fert, logic busy, logic [4:0] wa3);
    return {s, s, fdrs, fdrt, fers, fert, busy, wa3};
  endfunction

  function automatic logic [OUT_W-1:0] pack_dut();
    return {stall, flush_e, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy, w_a3};
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Present instr in D, sample at the falling edge, then advance one clock.
  task automatic cycle_out(input logic [31:0] instr, output logic [OUT_W-1:0] got);
    d_instr = instr;
    @(negedge clk);
    got = pack_dut();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Each in-flight instruction remembers the cycle it sat in E; its remaining
  // time to a usable result at cycle `now` is max(e_cycle + tnew - now, 0).
  typedef struct {
    int a3;
    int tnew;
    int rs;
    int rt;
    int tuse_rs;
    int tuse_rt;
    bit md;
    bit dv;
    bit hilo;
    int e_cycle;
  } ins_t;

  ins_t pe, pm, pw;
  int   now;
  int   last_md;
  int   last_len;

  function automatic ins_t bubble();
    ins_t b;
    b = '{default: 0};
    b.tuse_rs = -1;
    b.tuse_rt = -1;
    return b;
  endfunction

  function automatic ins_t decode(logic [31:0] ins);
    ins_t d;
    int op, fn, rs, rt, rd, sh;
    d  = bubble();
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    rd = int'(ins[15:11]);
    sh = int'(ins[10:6]);
    if (op == 0) begin
      if (sh == 0) begin
        case (fn)
          'h20, 'h22: begin d.a3 = rd; d.tnew = 1; d.tuse_rs = 1; d.tuse_rt = 1; end
          'h10, 'h12: begin d.a3 = rd; d.tnew = 1; d.hilo = 1; end
          'h11, 'h13: begin d.tuse_rs = 1; d.hilo = 1; end
          'h18, 'h19: begin d.tuse_rs = 1; d.tuse_rt = 1; d.md = 1; d.hilo = 1; end
          'h1a, 'h1b: begin d.tuse_rs = 1; d.tuse_rt = 1; d.md = 1; d.dv = 1; d.hilo = 1; end
          'h08:       begin d.tuse_rs = 0; end
          default: ;
        endcase
      end
    end else begin
      case (op)
        'h0d: begin d.a3 = rt; d.tnew = 1; d.tuse_rs = 1; end
        'h0f: begin d.a3 = rt; d.tnew = 1; end
        'h23: begin d.a3 = rt; d.tnew = 2; d.tuse_rs = 1; end
        'h2b: begin d.tuse_rs = 1; d.tuse_rt = 2; end
        'h04: begin d.tuse_rs = 0; d.tuse_rt = 0; end
        'h03: begin d.a3 = 31; d.tnew = 0; end
        default: ;
      endcase
    end
    d.rs = (d.tuse_rs >= 0) ? rs : 0;
    d.rt = (d.tuse_rt >= 0) ? rt : 0;
    return d;
  endfunction

  function automatic int remaining(ins_t s);
    int r;
    r = s.e_cycle + s.tnew - now;
    return (r > 0) ? r : 0;
  endfunction

  function automatic logic model_stall(ins_t d);
    logic s;
    bit   busy;
    s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      int r, tu;
      r  = (i == 0) ? d.rs : d.rt;
      tu = (i == 0) ? d.tuse_rs : d.tuse_rt;
      if (r != 0) begin
        if (pe.a3 == r && remaining(pe) > tu) s = 1'b1;
        if (pm.a3 == r && remaining(pm) > tu) s = 1'b1;
      end
    end
    busy = (now - last_md >= 1) && (now - last_md <= last_len);
    if (d.hilo && (busy || pe.md)) s = 1'b1;
    return s;
  endfunction

  function automatic logic [1:0] model_fwd_d(int r);
    if (r != 0 && pe.a3 == r && remaining(pe) == 0) return 2'b10;
    if (r != 0 && pm.a3 == r && remaining(pm) == 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] model_fwd_e(int r);
    if (r != 0 && pm.a3 == r && remaining(pm) == 0) return 2'b01;
    if (r != 0 && pw.a3 == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [OUT_W-1:0] model_out(ins_t d);
    logic busy;
    busy = (now - last_md >= 1) && (now - last_md <= last_len);
    return mk_out(model_stall(d), model_fwd_d(d.rs), model_fwd_d(d.rt),
                  model_fwd_e(pe.rs), model_fwd_e(pe.rt), busy, 5'(pw.a3));
  endfunction

  task automatic model_advance(input ins_t d, input logic s);
    if (pe.md) begin
      last_md  = now;
      last_len = pe.dv ? DIV_CYCLES : MULT_CYCLES;
    end
    pw = pm;
    pm = pe;
    pe = s ? bubble() : d;
    pe.e_cycle = now + 1;
    now++;
  endtask

  task automatic model_reset();
    pe       = bubble();
    pm       = bubble();
    pw       = bubble();
    now      = 0;
    last_md  = -1000;
    last_len = 0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 5));
    b = 5'($urandom_range(0, 5));
    c = 5'($urandom_range(0, 5));
    case ($urandom_range(0, 18))
      0:  return enc_r(a, b, c, 6'h20);
      1:  return enc_r(a, b, c, 6'h22);
      2:  return enc_i(6'h0d, a, b, 16'h0001);
      3:  return enc_i(6'h0f, 5'd0, b, 16'h1234);
      4:  return enc_i(6'h23, a, b, 16'h0004);
      5:  return enc_i(6'h2b, a, b, 16'h0008);
      6:  return enc_i(6'h04, a, b, 16'h0002);
      7:  return enc_jal();
      8:  return enc_r(5'd31, 5'd0, 5'd0, 6'h08);
      9:  return enc_r(a, b, 5'd0, 6'h18);
      10: return enc_r(a, b, 5'd0, 6'h19);
      11: return enc_r(a, b, 5'd0, 6'h1a);
      12: return enc_r(a, b, 5'd0, 6'h1b);
      13: return enc_r(5'd0, 5'd0, c, 6'h10);
      14: return enc_r(5'd0, 5'd0, c, 6'h12);
      15: return enc_r(a, 5'd0, 5'd0, 6'h11);
      16: return enc_r(a, 5'd0, 5'd0, 6'h13);
      17: return enc_r(a, b, c, 6'h00);
      default: return $urandom();
    endcase
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0]      instr;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic md_window(input logic [31:0] md_instr, input int n_cycles, input string name);
    logic [OUT_W-1:0] got;
    logic [31:0]      mflo3;
    int               cnt;
    bit               cleared;
    mflo3 = enc_r(5'd0, 5'd0, 5'd3, 6'h12);
    for (int i = 0; i < 3; i++) cycle_out(32'h0, got);
    cycle_out(md_instr, got);
    chk({name, "_issue_stall"}, OUT_W'(got[B_STALL]), OUT_W'(1'b0));
    cnt     = 0;
    cleared = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle_out(mflo3, got);
      if (k == 0) begin
        chk({name, "_t_busy"}, OUT_W'(got[B_BUSY]), OUT_W'(1'b0));
        chk({name, "_t_stall"}, OUT_W'(got[B_STALL]), OUT_W'(1'b1));
      end
      if (k == 1) chk({name, "_t1_busy"}, OUT_W'(got[B_BUSY]), OUT_W'(1'b1));
      if (!got[B_STALL]) begin
        cleared = 1'b1;
        break;
      end
      cnt++;
    end
    chk({name, "_cleared"}, OUT_W'(cleared), OUT_W'(1'b1));
    chk({name, "_stall_cycles"}, OUT_W'(cnt), OUT_W'(n_cycles + 1));
  endtask

  initial begin
    logic [OUT_W-1:0] got;
    logic [OUT_W-1:0] exp;
    logic [31:0]      cur;
    ins_t             dd;
    logic             s;

    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{enc_i(6'h23, 5'd0, 5'd1, 16'h0), mk_out(0, 0, 0, 0, 0, 0, 0)};   // lw $1,0($0)
    vecs[1]  = '{enc_r(5'd1, 5'd1, 5'd2, 6'h20), mk_out(1, 0, 0, 0, 0, 0, 0)};    // add $2,$1,$1
    vecs[2]  = '{enc_r(5'd1, 5'd1, 5'd2, 6'h20), mk_out(0, 0, 0, 0, 0, 0, 0)};    // same, released
    vecs[3]  = '{32'h0,                          mk_out(0, 0, 0, 2, 2, 0, 1)};    // add in E, from W
    vecs[4]  = '{enc_r(5'd1, 5'd2, 5'd3, 6'h20), mk_out(0, 0, 1, 0, 0, 0, 0)};    // add $3,$1,$2
    vecs[5]  = '{enc_r(5'd3, 5'd3, 5'd4, 6'h22), mk_out(0, 0, 0, 0, 2, 0, 2)};    // sub $4,$3,$3
    vecs[6]  = '{enc_r(5'd0, 5'd0, 5'd5, 6'h20), mk_out(0, 0, 0, 1, 1, 0, 0)};    // add $5; sub sees M
    vecs[7]  = '{enc_i(6'h04, 5'd5, 5'd0, 16'h2), mk_out(1, 0, 0, 0, 0, 0, 3)};   // beq $5,$0 stalls
    vecs[8]  = '{enc_i(6'h04, 5'd5, 5'd0, 16'h2), mk_out(0, 1, 0, 0, 0, 0, 4)};   // beq from M
    vecs[9]  = '{enc_jal(),                       mk_out(0, 0, 0, 2, 0, 0, 5)};   // jal
    vecs[10] = '{enc_r(5'd31, 5'd0, 5'd0, 6'h08), mk_out(0, 2, 0, 0, 0, 0, 0)};   // jr $31 from E
    vecs[11] = '{enc_i(6'h0d, 5'd0, 5'd0, 16'h1), mk_out(0, 0, 0, 1, 0, 0, 0)};   // ori $0,$0,1
    vecs[12] = '{enc_r(5'd0, 5'd0, 5'd6, 6'h20), mk_out(0, 0, 0, 0, 0, 0, 31)};   // reader of $0
    vecs[13] = '{32'h0,                          mk_out(0, 0, 0, 0, 0, 0, 0)};

    // reset
    reset   = 1'b0;
    d_instr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", pack_dut(), OUT_W'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      cycle_out(vecs[i].instr, got);
      chk($sformatf("vec%0d", i), got, vecs[i].exp);
    end

    md_window(enc_r(5'd1, 5'd2, 5'd0, 6'h18), MULT_CYCLES, "mult");
    md_window(enc_r(5'd1, 5'd2, 5'd0, 6'h1a), DIV_CYCLES, "div");

    // reset in the middle of a mult busy window
    for (int i = 0; i < 3; i++) cycle_out(32'h0, got);
    cycle_out(enc_r(5'd1, 5'd2, 5'd0, 6'h18), got);
    cycle_out(enc_r(5'd0, 5'd0, 5'd3, 6'h12), got);
    cycle_out(enc_r(5'd0, 5'd0, 5'd3, 6'h12), got);
    #1;
    chk("pre_reset_busy", OUT_W'(md_busy), OUT_W'(1'b1));
    chk("pre_reset_stall", OUT_W'(stall), OUT_W'(1'b1));
    reset = 1'b0;
    #1;
    chk("async_reset_busy", OUT_W'(md_busy), OUT_W'(1'b0));
    chk("async_reset_stall", OUT_W'(stall), OUT_W'(1'b0));
    d_instr = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cycle_out(32'h0, got);
      chk($sformatf("post_reset%0d", i), got, OUT_W'(0));
    end

    // randomized run against the reference model; D holds while stalled
    model_reset();
    cur = gen_instr();
    for (int i = 0; i < 600; i++) begin
      dd = decode(cur);
      s  = model_stall(dd);
      exp_q.push_back(model_out(dd));
      cycle_out(cur, got);
      exp = exp_q.pop_front();
      chk($sformatf("rand%0d_%h", i, cur), got, exp);
      model_advance(dd, s);
      if (!s) cur = gen_instr();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
